// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects, load-use bubble,
// taken-branch flush and hold/count sequencing for multi-cycle EX operations.
module ex_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int MC_CYCLES = 33
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_memread,
    input  logic              ex_mc_op,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              hold_idex,
    output logic              bubble_idex,
    output logic              bubble_exmem,
    output logic              flush_ifid,
    output logic              mc_start,
    output logic              mc_done
);

    localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, LDSTALL, MC_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lu;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] em_rd,
        input logic              em_wr,
        input logic [REG_AW-1:0] mw_rd,
        input logic              mw_wr
    );
        if (em_wr && em_rd != '0 && em_rd == rs)
            return 2'b10;
        else if (mw_wr && mw_rd != '0 && mw_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = id_ex_memread && (id_ex_rd != '0) &&
                ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
        ForwardA     = 2'b00;
        ForwardB     = 2'b00;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        hold_idex    = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        flush_ifid   = 1'b0;
        mc_start     = 1'b0;
        mc_done      = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;

        // Reset forces every output low combinationally, not just at the next edge.
        if (!clr) begin
            ForwardA = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
            ForwardB = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);

            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (ex_mc_op) begin
                        mc_start     = 1'b1;
                        stall_pc     = 1'b1;
                        stall_ifid   = 1'b1;
                        hold_idex    = 1'b1;
                        bubble_exmem = 1'b1;
                        cnt_nxt      = CW'(MC_CYCLES - 1);
                        state_nxt    = MC_WAIT;
                    end else if (lu) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        state_nxt   = LDSTALL;
                    end
                end
                // EX holds the inserted bubble here; lu is ignored so a held load
                // cannot stall twice.
                LDSTALL: begin
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                    state_nxt = RUN;
                end
                MC_WAIT: begin
                    if (cnt != '0) begin
                        stall_pc     = 1'b1;
                        stall_ifid   = 1'b1;
                        hold_idex    = 1'b1;
                        bubble_exmem = 1'b1;
                        cnt_nxt      = cnt - CW'(1);
                    end else begin
                        mc_done   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl (MC_CYCLES=4): the driver queues the
// expected outputs of each cycle, a monitor compares them at the falling edge.
module tb_ex_hazard_ctrl;

    localparam int AW = 5;

    // Control bits: stall_pc stall_ifid hold_idex bubble_idex bubble_exmem flush_ifid mc_start mc_done
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1101_0000;
    localparam logic [7:0] C_MCST  = 8'b1110_1010;
    localparam logic [7:0] C_HOLD  = 8'b1110_1000;
    localparam logic [7:0] C_DONE  = 8'b0000_0001;
    localparam logic [7:0] C_BR    = 8'b0001_0100;

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] ctl;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr;
    logic [AW-1:0] id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic          id_uses_rs2, id_ex_memread, ex_mc_op, branch_taken;
    logic          ex_mem_regwrite, mem_wb_regwrite;
    logic [1:0]    ForwardA, ForwardB;
    logic          stall_pc, stall_ifid, hold_idex, bubble_idex, bubble_exmem;
    logic          flush_ifid, mc_start, mc_done;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.REG_AW(AW), .MC_CYCLES(4)) dut (
        .clk(clk), .clr(clr),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_memread(id_ex_memread), .ex_mc_op(ex_mc_op), .branch_taken(branch_taken),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .hold_idex(hold_idex),
        .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
        .mc_start(mc_start), .mc_done(mc_done)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got fa=%b fb=%b ctl=%b, expected fa=%b fb=%b ctl=%b",
                     name, act[11:10], act[9:8], act[7:0], req[11:10], req[9:8], req[7:0]);
        end
    endtask

    // Monitor: the DUT is combinational per cycle, so every cycle with a queued
    // expectation is a presented response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name,
                      {ForwardA, ForwardB, stall_pc, stall_ifid, hold_idex, bubble_idex,
                       bubble_exmem, flush_ifid, mc_start, mc_done},
                      {e.fa, e.fb, e.ctl});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [7:0] ctl);
        exp_t e;
        e.name = name;
        e.fa   = fa;
        e.fb   = fb;
        e.ctl  = ctl;
        exp_q.push_back(e);
    endtask

    task automatic set_fwd(input logic [AW-1:0] em_rd, input logic em_wr,
                           input logic [AW-1:0] mw_rd, input logic mw_wr,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        ex_mem_rd = em_rd; ex_mem_regwrite = em_wr;
        mem_wb_rd = mw_rd; mem_wb_regwrite = mw_wr;
        id_ex_rs1 = rs1;   id_ex_rs2 = rs2;
    endtask

    task automatic set_ld(input logic rd_mem, input logic [AW-1:0] rd,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic use2);
        id_ex_memread = rd_mem; id_ex_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = use2;
    endtask

    initial begin
        int budget;
        clr = 1'b1;
        ex_mc_op = 1'b0; branch_taken = 1'b0;
        set_fwd('0, 1'b0, '0, 1'b0, '0, '0);
        set_ld(1'b0, '0, '0, '0, 1'b0);

        // Reset: outputs forced low even when forwarding would match.
        cyc(); set_fwd(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
        expect_out("reset_forced_zero", 2'b00, 2'b00, C_NONE);
        cyc(); clr = 1'b0;
        expect_out("release_fwd", 2'b10, 2'b10, C_NONE);

        // Forwarding priority and rd==0 guard.
        cyc(); set_fwd(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0);
        expect_out("fwd_exmem_prio", 2'b10, 2'b00, C_NONE);
        cyc(); set_fwd(5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 5'd5);
        expect_out("fwd_memwb", 2'b01, 2'b01, C_NONE);
        cyc(); set_fwd(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        expect_out("fwd_rd_zero", 2'b00, 2'b00, C_NONE);
        cyc(); set_fwd(5'd3, 1'b1, 5'd4, 1'b1, 5'd4, 5'd3);
        expect_out("fwd_mixed", 2'b01, 2'b10, C_NONE);
        cyc(); set_fwd('0, 1'b0, '0, 1'b0, '0, '0);
        expect_out("fwd_idle", 2'b00, 2'b00, C_NONE);

        // Load-use: one bubble, then one free cycle even with inputs held.
        cyc(); set_ld(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        expect_out("lu_rs1", 2'b00, 2'b00, C_LU);
        cyc(); expect_out("lu_held_ldstall", 2'b00, 2'b00, C_NONE);
        cyc(); expect_out("lu_held_again", 2'b00, 2'b00, C_LU);
        cyc(); set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_out("lu_clear", 2'b00, 2'b00, C_NONE);
        cyc(); set_ld(1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
        expect_out("lu_rs2", 2'b00, 2'b00, C_LU);
        cyc(); set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_out("lu_rs2_after", 2'b00, 2'b00, C_NONE);

        // No stall when rs2 unused or the load targets x0.
        cyc(); set_ld(1'b1, 5'd9, 5'd0, 5'd9, 1'b0);
        expect_out("lu_rs2_unused", 2'b00, 2'b00, C_NONE);
        cyc(); set_ld(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        expect_out("lu_rd_zero", 2'b00, 2'b00, C_NONE);

        // Branch beats load-use and stays in RUN.
        cyc(); set_ld(1'b1, 5'd7, 5'd7, 5'd0, 1'b0); branch_taken = 1'b1;
        expect_out("br_over_lu", 2'b00, 2'b00, C_BR);
        cyc(); branch_taken = 1'b0;
        expect_out("br_stayed_run", 2'b00, 2'b00, C_LU);
        cyc(); set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_out("br_lu_recover", 2'b00, 2'b00, C_NONE);

        // Multi-cycle op: start at T, holds T..T+3, done at T+4; re-assertions ignored.
        cyc(); ex_mc_op = 1'b1;
        expect_out("mc_start", 2'b00, 2'b00, C_MCST);
        cyc(); expect_out("mc_hold1", 2'b00, 2'b00, C_HOLD);
        cyc(); branch_taken = 1'b1;
        expect_out("mc_hold2_br_ign", 2'b00, 2'b00, C_HOLD);
        cyc(); branch_taken = 1'b0;
        expect_out("mc_hold3", 2'b00, 2'b00, C_HOLD);
        cyc(); ex_mc_op = 1'b0;
        expect_out("mc_done", 2'b00, 2'b00, C_DONE);
        cyc(); expect_out("mc_after", 2'b00, 2'b00, C_NONE);

        // clr during MC_WAIT aborts; no mc_done afterwards, forwarding resumes.
        cyc(); ex_mc_op = 1'b1;
        expect_out("abort_start", 2'b00, 2'b00, C_MCST);
        cyc(); expect_out("abort_hold1", 2'b00, 2'b00, C_HOLD);
        cyc(); clr = 1'b1; set_fwd(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 5'd5);
        expect_out("abort_clr_zero", 2'b00, 2'b00, C_NONE);
        cyc(); clr = 1'b0; ex_mc_op = 1'b0;
        expect_out("abort_release", 2'b10, 2'b10, C_NONE);
        cyc(); expect_out("abort_no_done1", 2'b10, 2'b10, C_NONE);
        cyc(); expect_out("abort_no_done2", 2'b10, 2'b10, C_NONE);
        cyc(); ex_mc_op = 1'b1; set_fwd('0, 1'b0, '0, 1'b0, '0, '0);
        expect_out("restart_in_run", 2'b00, 2'b00, C_MCST);
        cyc(); ex_mc_op = 1'b0;
        expect_out("restart_hold1", 2'b00, 2'b00, C_HOLD);
        cyc(); expect_out("restart_hold2", 2'b00, 2'b00, C_HOLD);
        cyc(); expect_out("restart_hold3", 2'b00, 2'b00, C_HOLD);
        cyc(); expect_out("restart_done", 2'b00, 2'b00, C_DONE);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
